reg_bank: RTL
=============

# reg_bank

General-purpose register bank of the multicycle MIPS datapath, directly downstream of the write-destination mux: its write address is the 5-bit register number that mux selects (rt, rd, $ra = 31, $sp = 29). It holds 32 architectural registers, provides two asynchronous read ports for rs/rt, and latches the operands into the A/B registers that feed the ALU stage. Register 0 is hardwired to zero, and $sp has a non-zero reset value.

## Interface
Parameters:
- DATA_W, 32, register and data width
- SP_RESET, 227, reset value of register 29 ($sp)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- reg_write  in  1  write enable from control unit
- write_reg  in  5  destination register number from the write-destination mux
- write_data  in  DATA_W  write-back value (ALU out / MDR / PC, selected upstream)
- read_reg1  in  5  rs field
- read_reg2  in  5  rt field
- read_data1  out  DATA_W  contents of read_reg1, combinational
- read_data2  out  DATA_W  contents of read_reg2, combinational
- load_a  in  1  capture read port 1 into A
- load_b  in  1  capture read port 2 into B
- a_out  out  DATA_W  A operand register
- b_out  out  DATA_W  B operand register

## Operation
- Storage: 31 flops-of-DATA_W for registers 1..31; register 0 is not stored and always reads 0.
- Write: at rising clk with reg_write=1 and write_reg≠0, reg[write_reg] ← write_data. Write to 0 is silently discarded. reg_write=0 leaves all registers unchanged.
- Read: read_dataN = (read_regN==0) ? 0 : reg[read_regN], purely combinational, no latency.
- Operand latches: at rising clk, a_out ← read_data1 if load_a; b_out ← read_data2 if load_b; otherwise hold. load_a and load_b are independent and may be asserted together.
- Reset (reset_n=0, asynchronous, takes effect immediately, including mid-instruction): all registers 0 except reg[29] = SP_RESET; a_out = 0; b_out = 0. read_data ports reflect reset contents combinationally. No write is performed while reset_n=0, even with reg_write=1.
- Release of reset is synchronous to clk by the surrounding design; the first write is accepted on the first rising edge with reset_n=1.

## Timing
- Write latency: 1 cycle; the written value appears on read_dataN after the same rising edge.
- Read-during-write on the same register in one cycle: read_dataN returns the old value before the edge (no bypass) unless RB_BYPASS_EN (see Configuration).
- Same-edge write and load_a/load_b targeting the written register: A/B capture the pre-write value without RB_BYPASS_EN.
- Write to 31 and 29 (jal/stack paths) behaves exactly like any other non-zero register.

## Configuration
- RB_BYPASS_EN defined: when reg_write=1, write_reg≠0 and write_reg==read_regN, read_dataN = write_data combinationally, so A/B capture the new value on a same-edge write. Register 0 is never bypassed.
- RB_BYPASS_EN undefined: no forwarding; reads always return stored contents. This is the default for the multicycle core, whose control unit never loads A/B in a write-back cycle.

## Structure
- Shared package (mips_pkg): REG_ZERO=0, REG_SP=29, REG_RA=31, REG_ADDR_W=5, and the 2-bit write-destination select encodings (00 rt, 01 rd, 10 $ra, 11 $sp) so the mux and control unit agree with this block.
- One natural sub-module: operand_reg (DATA_W-wide load-enabled register with asynchronous active-low clear), instantiated twice for A and B.

## Test plan
- Reset: pulse reset_n low mid-cycle -> immediately reg[29]=227, all other reads 0, a_out=b_out=0.
- Write/read: write 0xDEADBEEF to reg 8, then read_reg1=8 -> read_data1=0xDEADBEEF one cycle after the write edge; reg 9 still 0.
- Zero register: reg_write=1, write_reg=0, write_data=0xFFFFFFFF -> read of reg 0 stays 0.
- $ra/$sp: write 0x00000040 to 31 and 0x000000E0 to 29 -> reads return 0x40 and 0xE0; load_a/load_b with rs=31, rt=29 -> a_out=0x40, b_out=0xE0 after the edge.
- Same-edge write+load: reg 5=0x11, then write 0x22 to 5 with load_a=1, read_reg1=5 -> a_out=0x11 without RB_BYPASS_EN, 0x22 with it; reg 5 reads 0x22 afterwards in both builds.
- Write under reset: reset_n=0, reg_write=1 to reg 3 -> reg 3 reads 0 after reset release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register numbers and write-destination select codes.
// Latency: none (definitions only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // Write-destination mux select, shared with the control unit
  typedef enum logic [1:0] {
    WDST_RT = 2'b00,
    WDST_RD = 2'b01,
    WDST_RA = 2'b10,
    WDST_SP = 2'b11
  } wdst_sel_e;

endpackage

// File: rtl/reg_bank_operand_reg.sv
// Load-enabled operand register (A or B) with asynchronous active-low clear.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds when load is low.
module operand_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_bank.sv
// 32-entry MIPS register bank, $zero hardwired, $sp resets to SP_RESET; two async reads, A/B latches.
// Latency: reads combinational, writes and A/B loads 1 cycle; RB_BYPASS_EN forwards same-cycle writes.
// Backpressure: none; every enabled write/load is accepted on the rising edge.
module reg_bank
  import mips_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int unsigned SP_RESET = 227
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] read_reg1,
  input  logic [REG_ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0]     read_data1,
  output logic [DATA_W-1:0]     read_data2,
  input  logic                  load_a,
  input  logic                  load_b,
  output logic [DATA_W-1:0]     a_out,
  output logic [DATA_W-1:0]     b_out
);

  logic [DATA_W-1:0] regs_d [1:31];
  logic [DATA_W-1:0] regs_q [1:31];
  logic              wr_en;

  assign wr_en = reg_write && (write_reg != REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[write_reg] = write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= (5'(i) == REG_SP) ? DATA_W'(SP_RESET) : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg1 != REG_ZERO) read_data1 = regs_q[read_reg1];
    if (read_reg2 != REG_ZERO) read_data2 = regs_q[read_reg2];
`ifdef RB_BYPASS_EN
    // Forward only a write that will actually land; reset suppresses writes
    if (reset_n && wr_en && (write_reg == read_reg1)) read_data1 = write_data;
    if (reset_n && wr_en && (write_reg == read_reg2)) read_data2 = write_data;
`endif
  end

  operand_reg #(.DATA_W(DATA_W)) u_a_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_a),
    .d       (read_data1),
    .q       (a_out)
  );

  operand_reg #(.DATA_W(DATA_W)) u_b_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_b),
    .d       (read_data2),
    .q       (b_out)
  );

endmodule
